// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped byte TX FIFO plus 8N1 serial transmitter.
// Read data is registered one cycle after ren, matching ram32 on the same bus.
//
// Ports
//   clk        clock, all logic on posedge
//   resetn     synchronous active-low reset
//   sel        access targets this block; qualifies ren and bwe
//   addr[1:0]  word offset: 0 TXDATA, 1 STATUS, 2 DIVISOR, 3 TXCOUNT
//   din[31:0]  write data
//   bwe[3:0]   byte write enables; any set bit makes the access a write
//   ren        read strobe
//   dout[31:0] registered read data, holds between reads
//   tx         serial output, idle high
//   irq_empty  high while the FIFO is empty and the transmitter is idle
//
// TX FSM states
//   state    | meaning
//   ST_IDLE  | line idle high, waiting for a byte in the FIFO
//   ST_START | start bit (low) for div_frame cycles
//   ST_DATA  | eight data bits, LSB first, div_frame cycles each
//   ST_STOP  | stop bit (high); at its end the next byte starts with no gap
module mmio_uart_tx #(
    parameter int FIFO_DEPTH  = 16,
    parameter int DEFAULT_DIV = 868
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        sel,
    input  logic [1:0]  addr,
    input  logic [31:0] din,
    input  logic [3:0]  bwe,
    input  logic        ren,
    output logic [31:0] dout,
    output logic        tx,
    output logic        irq_empty
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [1:0] A_TXDATA  = 2'd0;
    localparam logic [1:0] A_STATUS  = 2'd1;
    localparam logic [1:0] A_DIVISOR = 2'd2;
    localparam logic [1:0] A_TXCOUNT = 2'd3;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          overflow;
    logic [15:0]   div_reg;
    logic [15:0]   div_frame;
    logic [15:0]   timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic [1:0]    state;
    logic [31:0]   txcount;

    logic          wr_en;
    logic          push_req;
    logic          fifo_push;
    logic          fifo_drop;
    logic          fifo_pop;
    logic          ovf_clear;
    logic          timer_done;
    logic          busy;
    logic [15:0]   div_merged;
    logic [31:0]   rdata;
    logic          unused_bits;

    assign unused_bits = ^{din[31:16], bwe[3:2]};

    assign full       = (count == CW'(FIFO_DEPTH));
    assign empty      = (count == '0);
    assign busy       = (state != ST_IDLE);
    assign irq_empty  = empty & ~busy;
    assign timer_done = (timer == 16'd0);

    assign wr_en     = sel & (|bwe);
    assign push_req  = wr_en & (addr == A_TXDATA) & bwe[0];
    // A full FIFO drops the byte even when a pop frees a slot on the same edge.
    assign fifo_push = push_req & ~full;
    assign fifo_drop = push_req & full;
    assign ovf_clear = wr_en & (addr == A_STATUS) & bwe[0] & din[3];
    // Pop from IDLE, or at the end of a stop bit so frames run back to back.
    assign fifo_pop  = ~empty & ((state == ST_IDLE) | ((state == ST_STOP) & timer_done));

    always_comb begin
        div_merged = div_reg;
        if (bwe[0]) div_merged[7:0]  = din[7:0];
        if (bwe[1]) div_merged[15:8] = din[15:8];
    end

    always_comb begin
        rdata = 32'd0;
        case (addr)
            A_STATUS:  rdata = {16'd0, 8'(count), 4'd0, overflow, busy, empty, full};
            A_DIVISOR: rdata = {16'd0, div_reg};
            A_TXCOUNT: rdata = txcount;
            default:   rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[wr_ptr] <= din[7:0];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            dout     <= 32'd0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            div_reg  <= 16'(DEFAULT_DIV);
        end else begin
            if (sel && ren) dout <= rdata;
            if (fifo_push) wr_ptr <= wr_ptr + AW'(1);
            if (fifo_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(fifo_push) - CW'(fifo_pop);
            if (fifo_drop)      overflow <= 1'b1;
            else if (ovf_clear) overflow <= 1'b0;
            if (wr_en && (addr == A_DIVISOR) && (|bwe[1:0]))
                div_reg <= (div_merged == 16'd0) ? 16'd1 : div_merged;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            tx        <= 1'b1;
            timer     <= 16'd0;
            div_frame <= 16'd1;
            bit_idx   <= 3'd0;
            shift_reg <= 8'd0;
            txcount   <= 32'd0;
        end else begin
            // tx is registered off the state, so every bit appears one cycle after its state.
            tx <= (state == ST_START) ? 1'b0 : (state == ST_DATA) ? shift_reg[0] : 1'b1;
            case (state)
                ST_START: begin
                    if (timer_done) begin
                        timer   <= div_frame - 16'd1;
                        bit_idx <= 3'd0;
                        state   <= ST_DATA;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (timer_done) begin
                        timer     <= div_frame - 16'd1;
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        if (bit_idx == 3'd7) state <= ST_STOP;
                        else                 bit_idx <= bit_idx + 3'd1;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (timer_done) begin
                        txcount <= txcount + 32'd1;
                        state   <= ST_IDLE;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                default: ;
            endcase
            // A pop overrides the transitions above; div is sampled only at frame start.
            if (fifo_pop) begin
                shift_reg <= fifo_mem[rd_ptr];
                div_frame <= div_reg;
                timer     <= div_reg - 16'd1;
                state     <= ST_START;
            end
        end
    end
endmodule
